// File: rtl/cpu_mem_arbiter.sv
// -----------------------------------------------------------------------------
// cpu_mem_arbiter
//
// Shares one single-word backing-memory port between the instruction cache and
// the data cache. One line transaction is granted at a time and broken into
// BEATS single-word accesses with only one access outstanding. Refill words
// are registered and returned beat by beat to the owning cache. A data-cache
// write-back finishes with a single write-done pulse (resp_valid + resp_last).
//
// Optional build macro:
//   CPU_MEM_ARB_RR_EN  - round-robin arbitration on simultaneous requests
//                        (undefined: data cache has fixed priority)
//
// Ports:
//   clock, reset      system clock (rising edge), async active-low reset
//   ic_req_*          icache line-read request (valid/ready/addr)
//   ic_resp_*         icache refill beats (valid/data/last)
//   dc_req_*          dcache line request (valid/ready/write/addr/wline)
//   dc_resp_*         dcache refill beats or write-done pulse
//   mem_req_*         single-word memory access (valid/ready/write/addr/wdata)
//   mem_rvalid/rdata  memory read return
//   busy              a line transaction is in progress
//   grant_dc          owner of current transaction (1 = dcache, 0 = icache)
//
// State table:
//   state | meaning
//   IDLE  | no transaction; arbitrate and accept one request
//   ADDR  | present access for current beat, wait for mem_req_ready
//   RDATA | read access issued, wait for mem_rvalid
// -----------------------------------------------------------------------------
module cpu_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int BEATS  = 4
) (
    input  logic                     clock,
    input  logic                     reset,

    input  logic                     ic_req_valid,
    output logic                     ic_req_ready,
    input  logic [ADDR_W-1:0]        ic_req_addr,
    output logic                     ic_resp_valid,
    output logic [DATA_W-1:0]        ic_resp_data,
    output logic                     ic_resp_last,

    input  logic                     dc_req_valid,
    output logic                     dc_req_ready,
    input  logic                     dc_req_write,
    input  logic [ADDR_W-1:0]        dc_req_addr,
    input  logic [DATA_W*BEATS-1:0]  dc_req_wline,
    output logic                     dc_resp_valid,
    output logic [DATA_W-1:0]        dc_resp_data,
    output logic                     dc_resp_last,

    output logic                     mem_req_valid,
    input  logic                     mem_req_ready,
    output logic                     mem_req_write,
    output logic [ADDR_W-1:0]        mem_req_addr,
    output logic [DATA_W-1:0]        mem_req_wdata,
    input  logic                     mem_rvalid,
    input  logic [DATA_W-1:0]        mem_rdata,

    output logic                     busy,
    output logic                     grant_dc
);

    localparam int WORD_BYTES = DATA_W / 8;
    localparam int LINE_BYTES = BEATS * WORD_BYTES;
    localparam int BEAT_W     = $clog2(BEATS);
    localparam int WORD_SHIFT = $clog2(WORD_BYTES);

    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_BYTES - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        RDATA
    } state_t;

    state_t                          state, state_d;
    logic [BEAT_W-1:0]               beat, beat_d;
    logic [ADDR_W-1:0]               base, base_d;
    logic                            is_write, is_write_d;
    logic [BEATS-1:0][DATA_W-1:0]    wline, wline_d;
    logic                            busy_d;
    logic                            grant_dc_d;

    logic                            ic_resp_valid_d;
    logic [DATA_W-1:0]               ic_resp_data_d;
    logic                            ic_resp_last_d;
    logic                            dc_resp_valid_d;
    logic [DATA_W-1:0]               dc_resp_data_d;
    logic                            dc_resp_last_d;

    logic                            dc_pick;

`ifdef CPU_MEM_ARB_RR_EN
    // Owner of the most recent acceptance; a tie goes to the other cache.
    logic                            last_dc, last_dc_d;

    always_comb begin
        dc_pick = dc_req_valid && !(ic_req_valid && last_dc);
    end
`else
    always_comb begin
        dc_pick = dc_req_valid;
    end
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            beat          <= '0;
            base          <= '0;
            is_write      <= 1'b0;
            wline         <= '0;
            busy          <= 1'b0;
            grant_dc      <= 1'b0;
            ic_resp_valid <= 1'b0;
            ic_resp_data  <= '0;
            ic_resp_last  <= 1'b0;
            dc_resp_valid <= 1'b0;
            dc_resp_data  <= '0;
            dc_resp_last  <= 1'b0;
`ifdef CPU_MEM_ARB_RR_EN
            last_dc       <= 1'b0;
`endif
        end else begin
            state         <= state_d;
            beat          <= beat_d;
            base          <= base_d;
            is_write      <= is_write_d;
            wline         <= wline_d;
            busy          <= busy_d;
            grant_dc      <= grant_dc_d;
            ic_resp_valid <= ic_resp_valid_d;
            ic_resp_data  <= ic_resp_data_d;
            ic_resp_last  <= ic_resp_last_d;
            dc_resp_valid <= dc_resp_valid_d;
            dc_resp_data  <= dc_resp_data_d;
            dc_resp_last  <= dc_resp_last_d;
`ifdef CPU_MEM_ARB_RR_EN
            last_dc       <= last_dc_d;
`endif
        end
    end

    always_comb begin
        state_d         = state;
        beat_d          = beat;
        base_d          = base;
        is_write_d      = is_write;
        wline_d         = wline;
        busy_d          = busy;
        grant_dc_d      = grant_dc;

        // Response pulses last one cycle; data holds between pulses.
        ic_resp_valid_d = 1'b0;
        ic_resp_data_d  = ic_resp_data;
        ic_resp_last_d  = 1'b0;
        dc_resp_valid_d = 1'b0;
        dc_resp_data_d  = dc_resp_data;
        dc_resp_last_d  = 1'b0;

        ic_req_ready    = 1'b0;
        dc_req_ready    = 1'b0;
        mem_req_valid   = 1'b0;
        mem_req_write   = 1'b0;
        mem_req_addr    = '0;
        mem_req_wdata   = '0;
`ifdef CPU_MEM_ARB_RR_EN
        last_dc_d       = last_dc;
`endif

        case (state)
            IDLE: begin
                // No acknowledge while reset is held, so nothing is accepted
                // that the reset would immediately throw away.
                if (reset) begin
                    dc_req_ready = dc_pick;
                    ic_req_ready = ic_req_valid && !dc_pick;
                end
                if (dc_req_ready || ic_req_ready) begin
                    state_d    = ADDR;
                    beat_d     = '0;
                    busy_d     = 1'b1;
                    grant_dc_d = dc_req_ready;
                    base_d     = (dc_req_ready ? dc_req_addr : ic_req_addr) & LINE_MASK;
                    is_write_d = dc_req_ready && dc_req_write;
                    wline_d    = dc_req_wline;
`ifdef CPU_MEM_ARB_RR_EN
                    last_dc_d  = dc_req_ready;
`endif
                end
            end

            ADDR: begin
                // Base is line-aligned, so the beat offset never carries into it.
                mem_req_valid = 1'b1;
                mem_req_addr  = base + (ADDR_W'(beat) << WORD_SHIFT);
                mem_req_write = is_write;
                mem_req_wdata = is_write ? wline[beat] : '0;
                if (mem_req_ready) begin
                    if (!is_write) begin
                        state_d = RDATA;
                    end else if (beat == LAST_BEAT) begin
                        dc_resp_valid_d = 1'b1;
                        dc_resp_last_d  = 1'b1;
                        dc_resp_data_d  = '0;
                        busy_d          = 1'b0;
                        state_d         = IDLE;
                    end else begin
                        beat_d = beat + BEAT_W'(1);
                    end
                end
            end

            RDATA: begin
                if (mem_rvalid) begin
                    if (grant_dc) begin
                        dc_resp_valid_d = 1'b1;
                        dc_resp_data_d  = mem_rdata;
                        dc_resp_last_d  = (beat == LAST_BEAT);
                    end else begin
                        ic_resp_valid_d = 1'b1;
                        ic_resp_data_d  = mem_rdata;
                        ic_resp_last_d  = (beat == LAST_BEAT);
                    end
                    if (beat == LAST_BEAT) begin
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        beat_d  = beat + BEAT_W'(1);
                        state_d = ADDR;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Self-checking bench for cpu_mem_arbiter (BEATS=4, 32-bit words).
// A transaction-level model tracks the owner, line base and beat of the
// current transaction; every negedge it predicts busy, grant, ready, memory
// access fields and response pulses, while also acting as the memory.
module tb_cpu_mem_arbiter;

    localparam int BEATS = 4;
    localparam int LINE  = BEATS * 4;

    logic          clock;
    logic          reset;
    logic          ic_req_valid, ic_req_ready;
    logic [31:0]   ic_req_addr;
    logic          ic_resp_valid, ic_resp_last;
    logic [31:0]   ic_resp_data;
    logic          dc_req_valid, dc_req_ready, dc_req_write;
    logic [31:0]   dc_req_addr;
    logic [127:0]  dc_req_wline;
    logic          dc_resp_valid, dc_resp_last;
    logic [31:0]   dc_resp_data;
    logic          mem_req_valid, mem_req_ready, mem_req_write;
    logic [31:0]   mem_req_addr, mem_req_wdata;
    logic          mem_rvalid;
    logic [31:0]   mem_rdata;
    logic          busy, grant_dc;

    cpu_mem_arbiter dut (
        .clock(clock), .reset(reset),
        .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready), .ic_req_addr(ic_req_addr),
        .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data), .ic_resp_last(ic_resp_last),
        .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_write(dc_req_write),
        .dc_req_addr(dc_req_addr), .dc_req_wline(dc_req_wline),
        .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data), .dc_resp_last(dc_resp_last),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_write(mem_req_write),
        .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .busy(busy), .grant_dc(grant_dc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic         dc;
        logic         wr;
        logic [31:0]  addr;
        logic [127:0] wline;
    } job_t;

    job_t         ic_jobs[$];
    job_t         dc_jobs[$];
    bit           grants[$];

    int           checks;
    int           errors;

    // transaction model
    bit           txn_active;
    job_t         cur;
    logic [31:0]  cur_base;
    int           cur_beat;
    bit           rr_last_dc;
    bit           pend_ic, pend_dc, pend_last;
    logic [31:0]  pend_data;
    logic [31:0]  last_ic_data, last_dc_data;

    // memory model
    bit           rd_out;
    int           rd_cnt, rd_delay;
    logic [31:0]  rd_addr;
    int           wait_cnt, stall_now, stall_max;
    bit           stall_rand, spur_en;
    logic [31:0]  hold_addr, hold_wdata;
    logic         hold_write;

    int           n_ic_beats, n_dc_resp, spur_cnt;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        if (a >= 32'h1000 && a <= 32'h100C) return 32'hA0 + ((a - 32'h1000) >> 2);
        return {a[15:0] ^ 16'hC3C3, a[31:16]};
    endfunction

    task automatic model_reset();
        txn_active   = 0;
        cur_beat     = 0;
        rr_last_dc   = 0;
        pend_ic      = 0;
        pend_dc      = 0;
        last_ic_data = '0;
        last_dc_data = '0;
        rd_out       = 0;
        wait_cnt     = 0;
        ic_jobs.delete();
        dc_jobs.delete();
        ic_req_valid  = 0;
        dc_req_valid  = 0;
        mem_req_ready = 0;
        mem_rvalid    = 0;
    endtask

    task automatic tick();
        bit   end_txn, exp_mem, exp_ic_rdy, exp_dc_rdy;
        job_t j;
        @(negedge clock);
        end_txn = 0;

        // registered outputs
        chk("busy", busy, txn_active);
        if (txn_active) chk("grant_dc", grant_dc, cur.dc);
        chk("ic_resp_valid", ic_resp_valid, pend_ic);
        chk("dc_resp_valid", dc_resp_valid, pend_dc);
        if (pend_ic) begin
            chk("ic_resp_data", ic_resp_data, pend_data);
            chk("ic_resp_last", ic_resp_last, pend_last);
            last_ic_data = pend_data;
            n_ic_beats++;
        end else begin
            chk("ic_resp_hold", ic_resp_data, last_ic_data);
        end
        if (pend_dc) begin
            chk("dc_resp_data", dc_resp_data, pend_data);
            chk("dc_resp_last", dc_resp_last, pend_last);
            last_dc_data = pend_data;
            n_dc_resp++;
        end else begin
            chk("dc_resp_hold", dc_resp_data, last_dc_data);
        end
        pend_ic = 0;
        pend_dc = 0;

        // memory side
        exp_mem = txn_active && !rd_out;
        chk("mem_req_valid", mem_req_valid, exp_mem);
        mem_req_ready = 0;
        mem_rvalid    = 0;
        mem_rdata     = $urandom;
        if (rd_out) begin
            if (rd_cnt == 0) begin
                mem_rvalid = 1;
                mem_rdata  = rd_word(rd_addr);
                rd_out     = 0;
                pend_ic    = !cur.dc;
                pend_dc    = cur.dc;
                pend_data  = rd_word(cur_base + 32'(cur_beat * 4));
                pend_last  = (cur_beat == BEATS - 1);
                if (cur_beat == BEATS - 1) end_txn = 1;
                else cur_beat++;
            end else begin
                rd_cnt--;
            end
        end else if (exp_mem) begin
            if (wait_cnt == 0) begin
                hold_addr  = mem_req_addr;
                hold_wdata = mem_req_wdata;
                hold_write = mem_req_write;
                stall_now  = stall_rand ? int'($urandom_range(0, stall_max)) : stall_max;
            end else begin
                chk("stall_addr", mem_req_addr, hold_addr);
                chk("stall_write", mem_req_write, hold_write);
                chk("stall_wdata", mem_req_wdata, hold_wdata);
            end
            if (wait_cnt >= stall_now) begin
                mem_req_ready = 1;
                wait_cnt      = 0;
                chk("mem_req_addr", mem_req_addr, cur_base + 32'(cur_beat * 4));
                chk("mem_req_write", mem_req_write, cur.wr);
                if (cur.wr) begin
                    chk("mem_req_wdata", mem_req_wdata, cur.wline[cur_beat*32 +: 32]);
                    if (cur_beat == BEATS - 1) begin
                        end_txn   = 1;
                        pend_dc   = 1;
                        pend_data = '0;
                        pend_last = 1;
                    end else begin
                        cur_beat++;
                    end
                end else begin
                    rd_out  = 1;
                    rd_cnt  = rd_delay;
                    rd_addr = mem_req_addr;
                end
            end else begin
                wait_cnt++;
            end
        end
        if (!rd_out && !mem_rvalid && spur_en && $urandom_range(0, 2) == 0) begin
            mem_rvalid = 1;
            spur_cnt++;
        end

        // request side
        ic_req_valid = (ic_jobs.size() > 0);
        ic_req_addr  = ic_req_valid ? ic_jobs[0].addr : $urandom;
        dc_req_valid = (dc_jobs.size() > 0);
        if (dc_req_valid) begin
            dc_req_addr  = dc_jobs[0].addr;
            dc_req_write = dc_jobs[0].wr;
            dc_req_wline = dc_jobs[0].wline;
        end else begin
            dc_req_addr  = $urandom;
            dc_req_write = $urandom_range(0, 1);
            dc_req_wline = {$urandom, $urandom, $urandom, $urandom};
        end
        #1;
`ifdef CPU_MEM_ARB_RR_EN
        exp_dc_rdy = !txn_active && dc_req_valid && !(ic_req_valid && rr_last_dc);
`else
        exp_dc_rdy = !txn_active && dc_req_valid;
`endif
        exp_ic_rdy = !txn_active && ic_req_valid && !exp_dc_rdy;
        chk("dc_req_ready", dc_req_ready, exp_dc_rdy);
        chk("ic_req_ready", ic_req_ready, exp_ic_rdy);
        if (dc_req_ready === 1'b1) grants.push_back(1'b1);
        else if (ic_req_ready === 1'b1) grants.push_back(1'b0);
        if (exp_dc_rdy || exp_ic_rdy) begin
            if (exp_dc_rdy) begin
                j = dc_jobs.pop_front();
            end else begin
                j = ic_jobs.pop_front();
                j.wr = 0;
            end
            cur        = j;
            cur_base   = j.addr & ~32'(LINE - 1);
            cur_beat   = 0;
            rr_last_dc = j.dc;
            txn_active = 1;
            wait_cnt   = 0;
        end
        if (end_txn) txn_active = 0;
    endtask

    task automatic push_job(input bit dc, input bit wr, input logic [31:0] addr,
                            input logic [127:0] wline);
        job_t j;
        j.dc    = dc;
        j.wr    = dc ? wr : 1'b0;
        j.addr  = addr;
        j.wline = wline;
        if (dc) dc_jobs.push_back(j);
        else ic_jobs.push_back(j);
    endtask

    task automatic run_until_idle(input int budget);
        int n;
        n = 0;
        while ((txn_active || pend_ic || pend_dc || ic_jobs.size() > 0 || dc_jobs.size() > 0)
               && n < budget) begin
            tick();
            n++;
        end
        chk("drain_timeout", (n < budget), 1'b1);
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_ic_req_ready"}, ic_req_ready, 1'b0);
        chk({pfx, "_dc_req_ready"}, dc_req_ready, 1'b0);
        chk({pfx, "_ic_resp"}, {ic_resp_valid, ic_resp_last, ic_resp_data}, '0);
        chk({pfx, "_dc_resp"}, {dc_resp_valid, dc_resp_last, dc_resp_data}, '0);
        chk({pfx, "_mem_req"}, {mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata}, '0);
        chk({pfx, "_busy_grant"}, {busy, grant_dc}, 2'b00);
    endtask

    task automatic do_reset();
        #1 reset = 0;
        model_reset();
        repeat (2) tick();
        reset = 1;
        tick();
    endtask

    initial begin
        bit   exp_g [4];
        int   g0;
        int   n;
        checks       = 0;
        errors       = 0;
        reset        = 0;
        ic_req_addr  = '0;
        dc_req_addr  = '0;
        dc_req_write = 0;
        dc_req_wline = '0;
        mem_rdata    = '0;
        stall_max    = 0;
        stall_rand   = 0;
        rd_delay     = 0;
        spur_en      = 0;
        model_reset();
        repeat (3) tick();
        chk_all_zero("reset");
        reset = 1;
        repeat (2) tick();

        // icache refill, zero-wait memory
        n_ic_beats = 0;
        n_dc_resp  = 0;
        push_job(0, 0, 32'h0000_1004, '0);
        run_until_idle(100);
        chk("t1_ic_beats", n_ic_beats, 4);
        chk("t1_dc_resp", n_dc_resp, 0);

        // dcache write-back, two stall cycles per beat
        stall_max  = 2;
        n_ic_beats = 0;
        n_dc_resp  = 0;
        push_job(1, 1, 32'h0000_2000, {32'hD3, 32'hD2, 32'hD1, 32'hD0});
        run_until_idle(100);
        chk("t2_dc_done", n_dc_resp, 1);
        chk("t2_ic_beats", n_ic_beats, 0);

        // spurious rvalid in IDLE and ADDR
        spur_en  = 1;
        rd_delay = 1;
        spur_cnt = 0;
        repeat (6) tick();
        push_job(0, 0, 32'h0000_5008, '0);
        push_job(1, 0, 32'h0000_6000, '0);
        run_until_idle(200);
        spur_en   = 0;
        stall_max = 0;

        // reset while beat 2 of an icache refill waits for read data
        rd_delay = 3;
        push_job(0, 0, 32'h0000_3000, '0);
        n = 0;
        while (!(txn_active && cur_beat == 2 && rd_out) && n < 100) begin
            tick();
            n++;
        end
        chk("t5_reach_beat2", (n < 100), 1'b1);
        tick();
        #1 reset = 0;
        #1;
        chk_all_zero("midreset");
        model_reset();
        repeat (2) tick();
        reset    = 1;
        rd_delay = 0;
        tick();
        push_job(1, 0, 32'h0000_401C, '0);
        run_until_idle(100);

        // simultaneous requests from a fresh reset
        do_reset();
        g0 = grants.size();
        push_job(0, 0, 32'h0000_7000, '0);
        push_job(0, 0, 32'h0000_7100, '0);
        push_job(1, 0, 32'h0000_8000, '0);
        push_job(1, 1, 32'h0000_8100, {$urandom, $urandom, $urandom, $urandom});
`ifdef CPU_MEM_ARB_RR_EN
        exp_g = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_g = '{1'b1, 1'b1, 1'b0, 1'b0};
`endif
        run_until_idle(300);
        chk("grant_count", grants.size() - g0, 4);
        for (int i = 0; i < 4 && g0 + i < grants.size(); i++)
            chk($sformatf("grant_order_%0d", i), grants[g0 + i], exp_g[i]);

        // randomized traffic
        stall_rand = 1;
        stall_max  = 2;
        spur_en    = 1;
        for (int c = 0; c < 1500; c++) begin
            rd_delay = $urandom_range(0, 2);
            if (ic_jobs.size() < 2 && $urandom_range(0, 7) == 0)
                push_job(0, 0, $urandom, '0);
            if (dc_jobs.size() < 2 && $urandom_range(0, 5) == 0)
                push_job(1, $urandom_range(0, 1), $urandom,
                         {$urandom, $urandom, $urandom, $urandom});
            tick();
        end
        run_until_idle(3000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
